// File: rtl/i2s_speaker_tx_if.sv
// Sample handshake and I2S output bundle for the speaker transmitter.
// master: the sample producer / observer side. slave: the transmitter itself.
interface i2s_speaker_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    sample_valid_in;
  logic [SAMPLE_WIDTH-1:0] sample_left_in;
  logic [SAMPLE_WIDTH-1:0] sample_right_in;
  logic                    sample_ready_out;
  logic                    i2s_sck_out;
  logic                    i2s_ws_out;
  logic                    i2s_sd_out;
  logic                    frame_start_out;
  logic                    underrun_out;

  modport master (
    output sample_valid_in, sample_left_in, sample_right_in,
    input  sample_ready_out, i2s_sck_out, i2s_ws_out, i2s_sd_out,
    input  frame_start_out, underrun_out
  );

  modport slave (
    input  sample_valid_in, sample_left_in, sample_right_in,
    output sample_ready_out, i2s_sck_out, i2s_ws_out, i2s_sd_out,
    output frame_start_out, underrun_out
  );
endinterface

// File: rtl/i2s_speaker_tx.sv
// I2S transmitter: divides clk_in down to SCK, runs a 64-slot frame with
// WS/SD updated on SCK falling edges, and feeds each frame from a one-entry
// holding register (zeros plus an underrun pulse when the register is empty).
module i2s_speaker_tx #(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  i2s_speaker_tx_if.slave bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]        div_cnt_reg, div_cnt_next;
  logic                    sck_reg, sck_next;
  logic [5:0]              slot_reg, slot_next;
  logic                    ws_reg, ws_next;
  logic                    sd_reg, sd_next;
  logic [63:0]             shift_reg, shift_next;
  logic                    hold_full_reg, hold_full_next;
  logic [SAMPLE_WIDTH-1:0] hold_left_reg, hold_left_next;
  logic [SAMPLE_WIDTH-1:0] hold_right_reg, hold_right_next;
  logic                    frame_start_reg, frame_start_next;
  logic                    underrun_reg, underrun_next;

  logic        tick;
  logic        fall;
  logic        transfer;
  logic [5:0]  slot_inc;
  logic [63:0] frame_word;

  // Frame image of the held pair: each channel MSB-first at the top of its
  // 32-bit slot, remaining slot bits zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_slot_bit
      if (gi < SAMPLE_WIDTH) begin : g_data
        assign frame_word[63-gi] = hold_left_reg[SAMPLE_WIDTH-1-gi];
        assign frame_word[31-gi] = hold_right_reg[SAMPLE_WIDTH-1-gi];
      end else begin : g_pad
        assign frame_word[63-gi] = 1'b0;
        assign frame_word[31-gi] = 1'b0;
      end
    end
  endgenerate

  assign tick     = (div_cnt_reg == DIV_LAST);
  assign fall     = tick && sck_reg;
  assign slot_inc = slot_reg + 6'd1;
  // Ready is held low throughout reset, not just after the first clock.
  assign bus.sample_ready_out = rst_n_in && !hold_full_reg;
  assign transfer = bus.sample_valid_in && bus.sample_ready_out;

  // Next-state: divider, slot/WS/SD on fall events, frame load, holding register.
  always_comb begin
    div_cnt_next     = div_cnt_reg + DIV_W'(1);
    sck_next         = sck_reg;
    slot_next        = slot_reg;
    ws_next          = ws_reg;
    sd_next          = sd_reg;
    shift_next       = shift_reg;
    hold_full_next   = hold_full_reg;
    hold_left_next   = hold_left_reg;
    hold_right_next  = hold_right_reg;
    frame_start_next = 1'b0;
    underrun_next    = 1'b0;

    if (tick) begin
      div_cnt_next = '0;
      sck_next     = !sck_reg;
    end

    if (fall) begin
      slot_next = slot_inc;
      // WS switches one slot ahead of each channel's MSB.
      ws_next   = (slot_inc >= 6'd31) && (slot_inc <= 6'd62);
      if (slot_reg == 6'd63) begin
        if (hold_full_reg) begin
          sd_next          = frame_word[63];
          shift_next       = {frame_word[62:0], 1'b0};
          hold_full_next   = 1'b0;
          frame_start_next = 1'b1;
        end else begin
          sd_next       = 1'b0;
          shift_next    = '0;
          underrun_next = 1'b1;
        end
      end else begin
        sd_next    = shift_reg[63];
        shift_next = {shift_reg[62:0], 1'b0};
      end
    end

    // Only possible while empty, so it never collides with the clear above;
    // a pair arriving on the boundary edge waits for the next frame.
    if (transfer) begin
      hold_left_next  = bus.sample_left_in;
      hold_right_next = bus.sample_right_in;
      hold_full_next  = 1'b1;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt_reg     <= '0;
      sck_reg         <= 1'b0;
      slot_reg        <= 6'd63;
      ws_reg          <= 1'b0;
      sd_reg          <= 1'b0;
      shift_reg       <= '0;
      hold_full_reg   <= 1'b0;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      sck_reg         <= sck_next;
      slot_reg        <= slot_next;
      ws_reg          <= ws_next;
      sd_reg          <= sd_next;
      shift_reg       <= shift_next;
      hold_full_reg   <= hold_full_next;
      hold_left_reg   <= hold_left_next;
      hold_right_reg  <= hold_right_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
    end
  end

  assign bus.i2s_sck_out     = sck_reg;
  assign bus.i2s_ws_out      = ws_reg;
  assign bus.i2s_sd_out      = sd_reg;
  assign bus.frame_start_out = frame_start_reg;
  assign bus.underrun_out    = underrun_reg;
endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Bench for i2s_speaker_tx: an arithmetic frame model predicts SCK, ready,
// pulses and per-frame content; a bench I2S receiver rebuilds each frame on
// SCK rise and checks it against the queued prediction.
module tb_i2s_speaker_tx;
  localparam int D       = 16;
  localparam int SW      = 16;
  localparam int FRAME   = 128 * D;
  localparam int FIRST_B = 2 * D;
  localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  i2s_speaker_tx_if #(.SAMPLE_WIDTH(SW)) bus ();

  i2s_speaker_tx #(.CLK_DIV(D), .SAMPLE_WIDTH(SW)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame boundaries fall every FRAME clocks, starting FIRST_B edges after release.
  function automatic bit is_boundary(input int n);
    return (n >= FIRST_B) && (((n - FIRST_B) % FRAME) == 0);
  endfunction

  // ---------------- reference model (posedge) ----------------
  int          edge_n = 0;
  bit          m_full = 1'b0;
  bit          m_was_full;
  bit          m_xfer;
  logic [15:0] m_l, m_r;
  bit          exp_fs = 1'b0, exp_ur = 1'b0, exp_ready = 1'b0, exp_sck = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      edge_n = 0;
      m_full = 1'b0;
      exp_q.delete();
      exp_fs = 1'b0; exp_ur = 1'b0; exp_ready = 1'b0; exp_sck = 1'b0;
    end else begin
      m_was_full = m_full;
      m_xfer     = bus.sample_valid_in && !m_was_full;
      edge_n++;
      exp_fs = 1'b0;
      exp_ur = 1'b0;
      if (is_boundary(edge_n)) begin
        if (m_was_full) begin
          exp_q.push_back({m_l, 16'h0000, m_r, 16'h0000});
          m_full = 1'b0;
          exp_fs = 1'b1;
        end else begin
          exp_q.push_back(64'h0);
          exp_ur = 1'b1;
        end
      end
      if (m_xfer) begin
        m_l    = bus.sample_left_in;
        m_r    = bus.sample_right_in;
        m_full = 1'b1;
      end
      exp_sck   = ((edge_n / D) % 2) == 1;
      exp_ready = !m_full;
    end
  end

  // ---------------- monitor / receiver (negedge) ----------------
  int          rise_cnt = 0;
  int          mon_slot = -1;
  int          frames_seen = 0;
  int          s;
  logic        prev_sck = 1'b0;
  logic [63:0] got_sd, got_ws, exp_frame;
  logic [3:0]  ctrl_got, ctrl_exp;
  logic [5:0]  all_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      all_out = {bus.i2s_sck_out, bus.i2s_ws_out, bus.i2s_sd_out,
                 bus.frame_start_out, bus.underrun_out, bus.sample_ready_out};
      tests++;
      if (all_out !== 6'b0) begin
        fails++;
        $display("[TB] FAIL reset_outputs got=%b want=000000", all_out);
      end
      rise_cnt = 0;
      mon_slot = -1;
      prev_sck = 1'b0;
    end else begin
      ctrl_got = {bus.i2s_sck_out, bus.frame_start_out, bus.underrun_out, bus.sample_ready_out};
      ctrl_exp = {exp_sck, exp_fs, exp_ur, exp_ready};
      tests++;
      if (ctrl_got !== ctrl_exp) begin
        fails++;
        $display("[TB] FAIL ctrl{sck,fs,ur,rdy} edge=%0d got=%b want=%b", edge_n, ctrl_got, ctrl_exp);
      end
      if (bus.i2s_sck_out && !prev_sck) begin
        if (rise_cnt > 0) begin
          s = (rise_cnt - 1) % 64;
          mon_slot = s;
          got_sd[63-s] = bus.i2s_sd_out;
          got_ws[63-s] = bus.i2s_ws_out;
          if (s == 63) begin
            frames_seen++;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("[TB] FAIL frame_queue frame=%0d got=data want=no_frame_pending", frames_seen);
            end else begin
              exp_frame = exp_q.pop_front();
              if (got_sd !== exp_frame) begin
                fails++;
                $display("[TB] FAIL frame_sd frame=%0d got=%h want=%h", frames_seen, got_sd, exp_frame);
              end
              tests++;
              if (got_ws !== WS_EXP) begin
                fails++;
                $display("[TB] FAIL frame_ws frame=%0d got=%h want=%h", frames_seen, got_ws, WS_EXP);
              end
              $display("[TB] frame %0d sd=%h ws=%h", frames_seen, got_sd, got_ws);
            end
          end
        end
        rise_cnt++;
      end
      prev_sck = bus.i2s_sck_out;
    end
  end

  // ---------------- stimulus ----------------
  // Present a pair at a negedge and hold it until a clock edge with ready high.
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int cnt;
    cnt = 0;
    bus.sample_valid_in = 1'b1;
    bus.sample_left_in  = l;
    bus.sample_right_in = r;
    while (!bus.sample_ready_out && cnt < 3 * FRAME) begin
      @(negedge clk);
      cnt++;
    end
    tests++;
    if (cnt >= 3 * FRAME) begin
      fails++;
      $display("[TB] FAIL send_timeout got=ready_low want=ready_within_%0d", 3 * FRAME);
    end else begin
      @(negedge clk);
      $display("[TB] transfer L=%h R=%h at edge %0d", l, r, edge_n);
    end
  endtask

  task automatic wait_boundary_passed();
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!is_boundary(edge_n) && cnt < 2 * FRAME);
  endtask

  initial begin
    int cnt;
    bus.sample_valid_in = 1'b0;
    bus.sample_left_in  = '0;
    bus.sample_right_in = '0;

    // Reset and idle start: first boundary underruns.
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Single known pair.
    send(16'hBEEF, 16'h1234);
    bus.sample_valid_in = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    // Streaming with valid held high.
    for (int i = 0; i < 16; i++) begin
      send(16'($urandom), 16'($urandom));
    end
    bus.sample_valid_in = 1'b0;

    // Starvation: five empty frames after the last streamed pair.
    repeat (6 * FRAME) @(negedge clk);

    // Boundary collision: pair arrives on the boundary edge with hold empty.
    cnt = 0;
    while (!is_boundary(edge_n + 1) && cnt < 2 * FRAME) begin
      @(negedge clk);
      cnt++;
    end
    bus.sample_valid_in = 1'b1;
    bus.sample_left_in  = 16'($urandom);
    bus.sample_right_in = 16'($urandom);
    @(negedge clk);
    $display("[TB] collision transfer L=%h R=%h at edge %0d", bus.sample_left_in, bus.sample_right_in, edge_n);
    bus.sample_valid_in = 1'b0;
    wait_boundary_passed();

    // Fill the holding register, then reset asynchronously during slot 40.
    send(16'($urandom), 16'($urandom));
    bus.sample_valid_in = 1'b0;
    cnt = 0;
    while (mon_slot != 40 && cnt < 2 * FRAME) begin
      @(negedge clk);
      cnt++;
    end
    tests++;
    if (mon_slot != 40) begin
      fails++;
      $display("[TB] FAIL slot40_wait got=%0d want=40", mon_slot);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    all_out = {bus.i2s_sck_out, bus.i2s_ws_out, bus.i2s_sd_out,
               bus.frame_start_out, bus.underrun_out, bus.sample_ready_out};
    tests++;
    if (all_out !== 6'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_async got=%b want=000000", all_out);
    end
    $display("[TB] mid-frame reset applied, outputs=%b", all_out);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;

    // Restart timing; hold must have been cleared by the reset.
    repeat (3 * FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2s_speaker_tx.md
# i2s_speaker_tx

I2S transmitter and bus master for the audio output path. It accepts stereo PCM sample pairs over a valid/ready handshake and generates the serial clock (SCK), word select (WS) and serial data (SD) for an external I2S DAC or amplifier. It is the outgoing counterpart of the microphone receive path: same 100 MHz system clock, 64-SCK frame and two's-complement MSB-first data.

## Interface
- CLK_DIV, 16, system clocks per SCK half-period; must be ≥2. At 100 MHz the default gives SCK = 3.125 MHz and a 48.83 kHz frame rate.
- SAMPLE_WIDTH, 16, bits per channel sample; must be ≤32. The slot width is fixed at 32 bits.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset. **One clock; reset is asynchronous and active-low.**
- sample_valid_in  input  1  a sample pair is presented.
- sample_left_in  input  SAMPLE_WIDTH  left sample, two's complement.
- sample_right_in  input  SAMPLE_WIDTH  right sample, two's complement.
- sample_ready_out  output  1  the holding register can accept a sample pair.
- i2s_sck_out  output  1  serial bit clock.
- i2s_ws_out  output  1  word select: 0 = left, 1 = right.
- i2s_sd_out  output  1  serial data.
- frame_start_out  output  1  one-cycle pulse when a held sample pair is loaded for transmission.
- underrun_out  output  1  one-cycle pulse when a frame starts with no sample held.

## Operation
Clock divider:
- div_cnt runs 0..CLK_DIV-1.
- On terminal count, div_cnt returns to 0 and i2s_sck_out toggles.
- A 0→1 toggle is a rise event; a 1→0 toggle is a fall event.

Slot counter:
- slot runs 0..63 and advances on every fall event, wrapping 63→0.

Word select (updated on fall events):
- i2s_ws_out = 1 for slots 31..62.
- i2s_ws_out = 0 for slot 63 and slots 0..30.
- WS therefore leads each channel's MSB by exactly one SCK.

Serial data (updated on fall events):
- Slots 0..SAMPLE_WIDTH-1 carry the left sample, MSB first.
- Slots 32..32+SAMPLE_WIDTH-1 carry the right sample, MSB first.
- All other slots carry 0.
- Implement as a 64-bit shift register loaded at the 63→0 wrap.

Holding register:
- One entry; hold_full flag.
- sample_ready_out = !hold_full, forced to 0 while rst_n_in is low.
- A transfer occurs when valid and ready are both high on a clk_in edge; it captures both samples and sets hold_full.

Frame boundary (the fall event that wraps slot 63→0):
- If hold_full: load the shift register from the holding register, clear hold_full, pulse frame_start_out.
- Otherwise: load all zeros and pulse underrun_out.
- A transfer on the same edge as a frame boundary with hold empty is not bypassed. That frame underruns, and the new pair is sent next frame.
- The held sample pair is never overwritten, because ready is 0 while the register is full.

No other states exist: the block is either in reset or running the divider/slot loop.

## Timing
- Reset values: i2s_sck_out=0, i2s_ws_out=0, i2s_sd_out=0, frame_start_out=0, underrun_out=0, div_cnt=0, slot=63, hold_full=0.
- Asserting reset clears all state immediately (asynchronously), mid-frame included.
- All I2S outputs are registered and change only on the clk_in edge of a toggle event. SD and WS change only on fall events, so they are stable across every SCK rising edge.
- After reset release:
  - First rise event at clock edge CLK_DIV.
  - First fall event, and first frame boundary, at edge 2·CLK_DIV.
- SCK period = 2·CLK_DIV clocks. Frame = 128·CLK_DIV clocks (2048 at default).
- Pulses on frame_start_out and underrun_out are exactly one clock wide. Exactly one of the two fires per frame boundary.
- sample_ready_out rises on the clock after a frame boundary that consumed a sample. It falls on the clock after a transfer.
- Latency from transfer to left MSB on SD: up to one frame plus one SCK.

## Test plan
- Reset: hold rst_n_in low for 10 clocks → all outputs 0 and ready 0. Release → ready=1; SCK first rises at edge 16 and falls at edge 32; underrun_out pulses at edge 32.
- Single pair, left=16'hBEEF, right=16'h1234, sent before the first boundary. A bench I2S receiver sampling SD on SCK rise recovers:
  - slots 0..15 = BEEF, slots 16..31 = 0;
  - slots 32..47 = 1234, slots 48..63 = 0;
  - WS rising at slot 31 and falling at slot 63.
- Streaming: 512 samples of 16'hBEEF·sin(i/5) with valid held high → all 512 pairs are recovered in order, with no underrun pulses after the first frame and exactly one transfer per 2048 clocks.
- Starvation: valid=0 for 5 frames → SD constant 0 and underrun_out pulses 5 times, 2048 clocks apart.
- Boundary collision: assert valid with hold empty on the exact frame-boundary edge → underrun that frame, and the pair appears in the following frame.
- Mid-frame reset: drop rst_n_in between clock edges during slot 40 → outputs go to 0 without a clock edge and hold_full clears. After release, timing restarts as in the reset scenario.
